// File: rtl/cpu_sched_pkg.sv
// rtl/cpu_sched_pkg.sv - shared latencies, RF select codes, FPU op codes and slot type for the issue scheduler
package cpu_sched_pkg;

    localparam int SLOT_DEPTH = 16;
    localparam int LAT_W      = 5;

    typedef logic [LAT_W-1:0] lat_t;

    localparam lat_t LAT_ALU   = 5'd1;
    localparam lat_t LAT_LOAD  = 5'd2;
    localparam lat_t LAT_FADD  = 5'd3;
    localparam lat_t LAT_FMUL  = 5'd4;
    localparam lat_t LAT_FDIV  = 5'd12;
    localparam lat_t LAT_FMISC = 5'd2;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_INT  = 2'b01;
    localparam logic [1:0] RW_FP   = 2'b10;
    localparam logic [1:0] RW_RSVD = 2'b11;

    localparam logic [4:0] F5_FADD = 5'b00000;
    localparam logic [4:0] F5_FSUB = 5'b00001;
    localparam logic [4:0] F5_FMUL = 5'b00010;
    localparam logic [4:0] F5_FDIV = 5'b00011;

    typedef struct packed {
        logic       v;
        logic       fp;
        logic [4:0] rd;
    } slot_t;

    // x0 in the integer RF is hardwired, so it can never be a RAW source.
    function automatic logic src_hit(input slot_t s, input logic [4:0] rs,
                                     input logic rs_fp, input logic use_rs);
        return use_rs && s.v && (s.fp == rs_fp) && (s.rd == rs) && (rs_fp || (rs != 5'd0));
    endfunction

endpackage

// File: rtl/fpu_lat_decode.sv
// rtl/fpu_lat_decode.sv - maps {memread, fpu, funct5} of the ID instruction to its writeback latency
module fpu_lat_decode
    import cpu_sched_pkg::*;
(
    input  logic       memread_i,
    input  logic       fpu_i,
    input  logic [4:0] funct5_i,
    output lat_t       lat_o,
    output logic       fdiv_o
);

    always_comb begin
        lat_o  = LAT_ALU;
        fdiv_o = 1'b0;
        if (memread_i) begin
            lat_o = LAT_LOAD;
        end else if (fpu_i) begin
            case (funct5_i)
                F5_FADD, F5_FSUB: lat_o = LAT_FADD;
                F5_FMUL:          lat_o = LAT_FMUL;
                F5_FDIV: begin
                    lat_o  = LAT_FDIV;
                    fdiv_o = 1'b1;
                end
                default:          lat_o = LAT_FMISC;
            endcase
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - ID-stage issue scheduler with writeback reservation shift register
// Define HAZARD_FWD_EN when the EX/WB bypass exists so the retiring slot 0 never raises RAW.
module issue_scheduler
    import cpu_sched_pkg::*;
#(
    parameter int DEPTH = SLOT_DEPTH
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       valid_id,
    input  logic [1:0] regwrite_id,
    input  logic       memread_id,
    input  logic       fpu_id,
    input  logic [4:0] funct5_id,
    input  logic [4:0] rd_id,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       use_rs1_id,
    input  logic       use_rs2_id,
    input  logic       rs1_fpu_id,
    input  logic       rs2_fpu_id,
    input  logic       flush_ex,
    output logic       stall_id,
    output logic       issue_id,
    output logic       wb_valid,
    output logic       wb_fp,
    output logic [4:0] wb_rd,
    output logic       div_busy
);

`ifdef HAZARD_FWD_EN
    localparam int FIRST_RAW_SLOT = 1;
`else
    localparam int FIRST_RAW_SLOT = 0;
`endif

    slot_t slot_q [DEPTH];
    slot_t slot_d [DEPTH];
    lat_t  div_cnt_q, div_cnt_d;
    logic  last_wr_q, last_wr_d;
    lat_t  last_idx_q, last_idx_d;
    logic  last_fdiv_q, last_fdiv_d;

    lat_t  lat;
    logic  is_fdiv;
    logic  wr_en;
    logic  raw;
    logic  collision;
    logic  div_haz;

    fpu_lat_decode u_lat (
        .memread_i (memread_id),
        .fpu_i     (fpu_id),
        .funct5_i  (funct5_id),
        .lat_o     (lat),
        .fdiv_o    (is_fdiv)
    );

    assign wr_en = !(regwrite_id inside {RW_NONE, RW_RSVD});

    always_comb begin
        raw       = 1'b0;
        collision = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= FIRST_RAW_SLOT) begin
                if (src_hit(slot_q[i], rs1_id, rs1_fpu_id, use_rs1_id) ||
                    src_hit(slot_q[i], rs2_id, rs2_fpu_id, use_rs2_id)) begin
                    raw = 1'b1;
                end
            end
            // Writing into slot L-1 after the shift means slot L must be free now.
            if (wr_en && slot_q[i].v && (lat == LAT_W'(i))) begin
                collision = 1'b1;
            end
        end
        div_haz  = is_fdiv && div_busy;
        stall_id = valid_id && (raw || collision || div_haz) && !flush_ex;
        issue_id = valid_id && !stall_id && !flush_ex;
    end

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            slot_d[i] = slot_q[i+1];
        end
        slot_d[DEPTH-1] = '0;

        // The flushed entry has shifted down by one this edge; slot 0 is already retiring.
        if (flush_ex && last_wr_q) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (last_idx_q == LAT_W'(i + 1)) begin
                    slot_d[i] = '0;
                end
            end
        end

        if (issue_id && wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lat == LAT_W'(i + 1)) begin
                    slot_d[i] = '{v: 1'b1, fp: (regwrite_id == RW_FP), rd: rd_id};
                end
            end
        end

        if (issue_id && is_fdiv) begin
            div_cnt_d = LAT_FDIV - LAT_W'(1);
        end else if (flush_ex && last_fdiv_q) begin
            div_cnt_d = '0;
        end else if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - LAT_W'(1);
        end else begin
            div_cnt_d = '0;
        end

        last_wr_d   = issue_id && wr_en;
        last_idx_d  = lat - LAT_W'(1);
        last_fdiv_d = issue_id && is_fdiv;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            div_cnt_q   <= '0;
            last_wr_q   <= 1'b0;
            last_idx_q  <= '0;
            last_fdiv_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            div_cnt_q   <= div_cnt_d;
            last_wr_q   <= last_wr_d;
            last_idx_q  <= last_idx_d;
            last_fdiv_q <= last_fdiv_d;
        end
    end

    assign wb_valid = slot_q[0].v;
    assign wb_fp    = slot_q[0].v && slot_q[0].fp;
    assign wb_rd    = slot_q[0].v ? slot_q[0].rd : 5'd0;
    assign div_busy = (div_cnt_q != '0);

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - directed self-checking bench for issue_scheduler (honours HAZARD_FWD_EN)
module tb_issue_scheduler;
    import cpu_sched_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       valid_id;
    logic [1:0] regwrite_id;
    logic       memread_id;
    logic       fpu_id;
    logic [4:0] funct5_id;
    logic [4:0] rd_id;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       use_rs1_id;
    logic       use_rs2_id;
    logic       rs1_fpu_id;
    logic       rs2_fpu_id;
    logic       flush_ex;
    logic       stall_id;
    logic       issue_id;
    logic       wb_valid;
    logic       wb_fp;
    logic [4:0] wb_rd;
    logic       div_busy;

    issue_scheduler dut (
        .clk         (clk),
        .rstn        (rstn),
        .valid_id    (valid_id),
        .regwrite_id (regwrite_id),
        .memread_id  (memread_id),
        .fpu_id      (fpu_id),
        .funct5_id   (funct5_id),
        .rd_id       (rd_id),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .use_rs1_id  (use_rs1_id),
        .use_rs2_id  (use_rs2_id),
        .rs1_fpu_id  (rs1_fpu_id),
        .rs2_fpu_id  (rs2_fpu_id),
        .flush_ex    (flush_ex),
        .stall_id    (stall_id),
        .issue_id    (issue_id),
        .wb_valid    (wb_valid),
        .wb_fp       (wb_fp),
        .wb_rd       (wb_rd),
        .div_busy    (div_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int wbq[$];
    int busy_total = 0;
    int n_cmp = 0;
    int n_mis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wb_valid) wbq.push_back(cyc * 64 + int'(wb_fp) * 32 + int'(wb_rd));
        if (div_busy) busy_total <= busy_total + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int find_wb(input int fp, input int rd, input int from);
        foreach (wbq[k]) begin
            if ((wbq[k] / 64) >= from && ((wbq[k] >> 5) & 1) == fp && (wbq[k] & 31) == rd)
                return wbq[k] / 64;
        end
        return -1;
    endfunction

    function automatic int count_wb(input int from);
        int n = 0;
        foreach (wbq[k]) if ((wbq[k] / 64) >= from) n++;
        return n;
    endfunction

    task automatic put(input logic v, input logic [1:0] rw, input logic mr, input logic fp,
                       input logic [4:0] f5, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic s1f, input logic s2f);
        valid_id    = v;
        regwrite_id = rw;
        memread_id  = mr;
        fpu_id      = fp;
        funct5_id   = f5;
        rd_id       = rd;
        rs1_id      = rs1;
        rs2_id      = rs2;
        use_rs1_id  = u1;
        use_rs2_id  = u2;
        rs1_fpu_id  = s1f;
        rs2_fpu_id  = s2f;
    endtask

    task automatic idle();
        put(1'b0, RW_NONE, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the driven instruction until it issues; returns stall cycles and the issue cycle.
    task automatic issue_wait(input string tag, output int stalls, output int icyc);
        bit done = 1'b0;
        stalls = 0;
        icyc   = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (issue_id) begin
                done = 1'b1;
                icyc = cyc;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk({tag, "_issue_timeout"}, int'(done), 1);
    endtask

    int s, c0, c1, c2, b0, b1;
    logic [4:0] f5_misc;

    initial begin
        f5_misc  = 5'b00100;
        rstn     = 1'b0;
        flush_ex = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall_id", int'(stall_id), 0);
        chk("rst_issue_id", int'(issue_id), 0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_wb_fp",    int'(wb_fp),    0);
        chk("rst_wb_rd",    int'(wb_rd),    0);
        chk("rst_div_busy", int'(div_busy), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        wait_cycles(2);

        // addi x5,x0 then add x6,x5,x5
        put(1'b1, RW_INT, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue_wait("t1_addi", s, c0);
        chk("t1_addi_stalls", s, 0);
        put(1'b1, RW_INT, 1'b0, 1'b0, 5'd0, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        issue_wait("t1_add", s, c1);
        chk("t1_add_stalls", s, (FWD != 0) ? 0 : 1);
        idle();
        wait_cycles(16);
        chk("t1_wb_x5_cycle", find_wb(0, 5, c0), c0 + 1);
        chk("t1_wb_x6_cycle", find_wb(0, 6, c0), c1 + 1);

        // lw x7 then addi x8,x7
        put(1'b1, RW_INT, 1'b1, 1'b0, 5'd0, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue_wait("t2_lw", s, c0);
        chk("t2_lw_stalls", s, 0);
        put(1'b1, RW_INT, 1'b0, 1'b0, 5'd0, 5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue_wait("t2_addi", s, c1);
        chk("t2_addi_stalls", s, (FWD != 0) ? 1 : 2);
        idle();
        wait_cycles(16);
        chk("t2_wb_x7_int_cycle", find_wb(0, 7, c0), c0 + 2);
        chk("t2_wb_x7_fp_absent", find_wb(1, 7, c0), -1);

        // fmul f1 then fadd f2,f3,f4: writeback-port collision
        put(1'b1, RW_FP, 1'b0, 1'b1, F5_FMUL, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        issue_wait("t3_fmul", s, c0);
        put(1'b1, RW_FP, 1'b0, 1'b1, F5_FADD, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        issue_wait("t3_fadd", s, c1);
        chk("t3_fadd_stalls", s, 1);
        idle();
        wait_cycles(16);
        chk("t3_wb_f1_cycle", find_wb(1, 1, c0), c0 + 4);
        chk("t3_wb_f2_cycle", find_wb(1, 2, c0), c0 + 5);

        // fdiv f10 then fdiv f11: non-pipelined divider
        b0 = busy_total;
        put(1'b1, RW_FP, 1'b0, 1'b1, F5_FDIV, 5'd10, 5'd20, 5'd21, 1'b1, 1'b1, 1'b1, 1'b1);
        issue_wait("t4_fdiv0", s, c0);
        put(1'b1, RW_FP, 1'b0, 1'b1, F5_FDIV, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b1, 1'b1);
        issue_wait("t4_fdiv1", s, c1);
        b1 = busy_total;
        chk("t4_fdiv1_stalls", s, 11);
        chk("t4_div_busy_cycles", b1 - b0, 11);
        idle();
        wait_cycles(30);
        chk("t4_div_busy_idle", int'(div_busy), 0);
        chk("t4_wb_f10_cycle", find_wb(1, 10, c0), c0 + 12);
        chk("t4_wb_f11_cycle", find_wb(1, 11, c0), c0 + 24);

        // lw x9, flushed the next cycle, then addi x20,x9
        put(1'b1, RW_INT, 1'b1, 1'b0, 5'd0, 5'd9, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue_wait("t5_lw", s, c0);
        put(1'b1, RW_INT, 1'b0, 1'b0, 5'd0, 5'd20, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        flush_ex = 1'b1;
        @(negedge clk);
        chk("t5_flush_issue_id", int'(issue_id), 0);
        chk("t5_flush_stall_id", int'(stall_id), 0);
        @(posedge clk);
        #1;
        flush_ex = 1'b0;
        issue_wait("t5_addi", s, c1);
        chk("t5_addi_stalls", s, 0);
        idle();
        wait_cycles(16);
        chk("t5_wb_x9_absent", find_wb(0, 9, c0), -1);
        chk("t5_wb_x20_cycle", find_wb(0, 20, c0), c1 + 1);

        // three reservations pending, then a one-cycle reset pulse
        put(1'b1, RW_FP, 1'b0, 1'b1, F5_FDIV, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        issue_wait("t6_fdiv", s, c0);
        put(1'b1, RW_FP, 1'b0, 1'b1, F5_FMUL, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        issue_wait("t6_fmul", s, c1);
        put(1'b1, RW_FP, 1'b0, 1'b1, f5_misc, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        issue_wait("t6_fmisc", s, c2);
        chk("t6_fmisc_stalls", s, 0);
        idle();
        chk("t6_div_busy_pre", int'(div_busy), 1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_div_busy", int'(div_busy), 0);
        chk("t6_rst_wb_valid", int'(wb_valid), 0);
        chk("t6_rst_wb_rd",    int'(wb_rd),    0);
        chk("t6_rst_stall_id", int'(stall_id), 0);
        c0 = cyc;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        wait_cycles(20);
        chk("t6_wb_after_reset", count_wb(c0), 0);
        chk("t6_div_busy_after", int'(div_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
